// File: rtl/bist_controller.sv
// BIST sequencer: seeds the PRNG and signature analyzer, runs N patterns, drains
// the datapath, stops the analyzer and compares the returned signature to golden.
module bist_controller #(
    parameter int DATA_WIDTH     = 54,
    parameter int CNT_WIDTH      = 16,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [CNT_WIDTH-1:0]  i_num_patterns,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic [DATA_WIDTH-1:0] i_golden,
    output logic                  o_prng_load,
    output logic                  o_prng_en,
    output logic [DATA_WIDTH-1:0] o_prng_seed,
    output logic                  o_sa_clr,
    output logic                  o_sa_mode,
    output logic                  o_sa_stop,
    output logic [DATA_WIDTH-1:0] o_sa_seed,
    input  logic                  i_sa_vld,
    input  logic [DATA_WIDTH-1:0] i_sa_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [DATA_WIDTH-1:0] o_signature
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_RUN, S_DRAIN, S_WAIT_SIG, S_DONE
    } state_e;

    // DRAIN_CYCLES=0 still spends one pass-through cycle in DRAIN.
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST   = (DRAIN_CYCLES > 1) ? DCW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [TCW-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 1) ? TCW'(TIMEOUT_CYCLES - 1) : '0;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, num_q, num_d;
    logic [DCW-1:0]        dcnt_q, dcnt_d;
    logic [TCW-1:0]        wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d, golden_q, golden_d, sig_q, sig_d;
    logic                  pass_q, pass_d, tout_q, tout_d;
    logic                  load_q, load_d, en_q, en_d, clr_q, clr_d, mode_q, mode_d;
    logic                  stop_q, stop_d, busy_q, busy_d, done_q, done_d;

    // NOTE: sequential state uses non-blocking assignments only; the reset is
    // synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            dcnt_q   <= '0;
            wcnt_q   <= '0;
            seed_q   <= '0;
            golden_q <= '0;
            sig_q    <= '0;
            pass_q   <= 1'b0;
            tout_q   <= 1'b0;
            load_q   <= 1'b0;
            en_q     <= 1'b0;
            clr_q    <= 1'b0;
            mode_q   <= 1'b0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            dcnt_q   <= dcnt_d;
            wcnt_q   <= wcnt_d;
            seed_q   <= seed_d;
            golden_q <= golden_d;
            sig_q    <= sig_d;
            pass_q   <= pass_d;
            tout_q   <= tout_d;
            load_q   <= load_d;
            en_q     <= en_d;
            clr_q    <= clr_d;
            mode_q   <= mode_d;
            stop_q   <= stop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        dcnt_d   = dcnt_q;
        wcnt_d   = wcnt_q;
        seed_d   = seed_q;
        golden_d = golden_q;
        sig_d    = sig_q;
        pass_d   = pass_q;
        tout_d   = tout_q;
        if (i_abort) begin
            state_d = S_IDLE;
            sig_d   = '0;
            pass_d  = 1'b0;
            tout_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        num_d    = i_num_patterns;
                        seed_d   = i_seed;
                        golden_d = i_golden;
                        sig_d    = '0;
                        pass_d   = 1'b0;
                        tout_d   = 1'b0;
                        state_d  = S_SEED;
                    end
                end
                S_SEED: begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = (num_q == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (cnt_q == num_q - 1'b1) begin
                        state_d = S_DRAIN;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == DRAIN_LAST) begin
                        wcnt_d  = '0;
                        state_d = S_WAIT_SIG;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                S_WAIT_SIG: begin
                    if (i_sa_vld) begin
                        sig_d   = i_sa_data;
                        pass_d  = (i_sa_data == golden_q);
                        state_d = S_DONE;
                    end else if (wcnt_q == TIMEOUT_LAST) begin
                        tout_d  = 1'b1;
                        pass_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so pulses are glitch-free.
    always_comb begin
        load_d = (state_d == S_SEED);
        clr_d  = (state_d == S_SEED);
        en_d   = (state_d == S_RUN);
        mode_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        stop_d = (state_d == S_WAIT_SIG) && (state_q != S_WAIT_SIG);
        busy_d = (state_d == S_SEED) || (state_d == S_RUN) ||
                 (state_d == S_DRAIN) || (state_d == S_WAIT_SIG);
        done_d = (state_d == S_DONE);
    end

    assign o_prng_load = load_q;
    assign o_prng_en   = en_q;
    assign o_prng_seed = seed_q;
    assign o_sa_clr    = clr_q;
    assign o_sa_mode   = mode_q;
    assign o_sa_stop   = stop_q;
    assign o_sa_seed   = seed_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_timeout   = tout_q;
    assign o_signature = sig_q;

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 54, giving the seed/signature width (x 18, y 18, z 18).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the pattern-count width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, giving the datapath latency flushed before stop.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum wait for the signature.
REQ-005 SHALL use one clock; reset is synchronous and active-low; ports i_clk (input, 1, rising-edge clock) and i_rst_n (input, 1, sync active-low reset).
REQ-006 SHALL have ports: i_start (in, 1, start test); i_abort (in, 1, abort test); i_num_patterns (in, CNT_WIDTH, pattern count); i_seed (in, DATA_WIDTH, PRNG/MISR seed); i_golden (in, DATA_WIDTH, expected signature).
REQ-007 SHALL have PRNG ports: o_prng_load (out, 1, seed load pulse); o_prng_en (out, 1, advance PRNG); o_prng_seed (out, DATA_WIDTH, latched seed).
REQ-008 SHALL have analyzer ports: o_sa_clr (out, 1, active-high analyzer reset pulse); o_sa_mode (out, 1, 0 = seed, 1 = compress); o_sa_stop (out, 1, stop pulse); o_sa_seed (out, DATA_WIDTH); i_sa_vld (in, 1); i_sa_data (in, DATA_WIDTH).
REQ-009 SHALL have status ports: o_busy, o_done, o_pass, o_timeout (out, 1 each); o_signature (out, DATA_WIDTH, captured signature).

Function
REQ-010 SHALL implement the states IDLE, SEED, RUN, DRAIN, WAIT_SIG and DONE, with the state registered.
REQ-011 SHALL, in IDLE or DONE with i_start=1 and i_abort=0, latch i_num_patterns, i_seed and i_golden, clear o_done/o_pass/o_timeout/o_signature, and enter SEED the next cycle.
REQ-012 SHALL, in SEED (exactly 1 cycle), assert o_prng_load=1, o_sa_clr=1 and o_sa_mode=0, then go to RUN, or to DRAIN if the latched count is 0.
REQ-013 SHALL, in RUN, assert o_prng_en=1 and o_sa_mode=1 and increment the pattern counter from 0, so that exactly N cycles of o_prng_en occur for count N; at counter==N-1 the next state is DRAIN.
REQ-014 SHALL, in DRAIN, hold o_sa_mode=1 and o_prng_en=0 for DRAIN_CYCLES cycles (0 means a single pass-through cycle), then go to WAIT_SIG.
REQ-015 SHALL assert o_sa_stop=1 for exactly the first cycle of WAIT_SIG.
REQ-016 SHALL, in WAIT_SIG on i_sa_vld=1, capture i_sa_data into o_signature, set o_pass=(i_sa_data==i_golden latched value), and go to DONE.
REQ-017 SHALL, in WAIT_SIG, set o_timeout=1 and o_pass=0 and go to DONE if TIMEOUT_CYCLES elapse without i_sa_vld.
REQ-018 SHALL ignore i_sa_vld in every state other than WAIT_SIG.
REQ-019 SHALL hold o_done=1 in DONE, with o_signature, o_pass and o_timeout stable until the next start.
REQ-020 SHALL drive o_busy=1 in SEED, RUN, DRAIN and WAIT_SIG, and 0 otherwise.
REQ-021 SHALL ignore i_start while busy.
REQ-022 SHALL, on i_abort=1 in any state, enter IDLE next cycle with all pulses deasserted and status cleared; i_abort has priority over i_start and i_sa_vld.
REQ-023 SHALL drive o_prng_seed and o_sa_seed from the latched seed register.
REQ-024 SHALL drive o_prng_load, o_sa_clr and o_sa_stop as single-cycle registered pulses, never asserted in the same cycle as o_prng_en.
REQ-025 SHALL let the pattern counter saturate with no wrap; for i_num_patterns=2^CNT_WIDTH-1, RUN lasts exactly that many cycles.

Reset
REQ-026 SHALL, while i_rst_n=0 at a clock edge, go to IDLE and drive all outputs, counters and latched registers to 0.
REQ-027 SHALL abandon a test in progress when reset is asserted, with no stop pulse issued.
REQ-028 SHALL, in the first cycle after reset release, accept i_start.

Verification
REQ-029 SHALL cover: N=5, golden matches, analyzer vld 2 cycles after stop -> 1 load, 5 en, 4 drain, stop, then o_done=1 and o_pass=1.
REQ-030 SHALL cover: N=5, golden differs in bit 0 -> o_done=1, o_pass=0, o_timeout=0, and o_signature equals the analyzer data.
REQ-031 SHALL cover: N=0 -> SEED to DRAIN directly, zero en cycles, stop issued, completes normally.
REQ-032 SHALL cover: no i_sa_vld -> o_timeout=1 and o_pass=0 after 64 WAIT_SIG cycles, with o_done=1.
REQ-033 SHALL cover: i_abort on cycle 3 of RUN together with i_start -> IDLE next cycle, o_busy=0, no stop pulse.
REQ-034 SHALL cover: i_rst_n=0 mid-DRAIN, then i_start right after release -> clean rerun with identical o_signature.
